addsub_pipe: RTL

Parametrised, pipelined add/subtract unit; the sequential successor to the team's 32-bit combinational subtractor. The operand word is split into SLICE-bit slices. Each pipeline stage resolves one slice and passes its carry to the next stage. Per-transaction add/sub mode, valid/ready handshakes on both sides with backpressure, and carry/overflow/zero flags; sits between the operand register file and the ALU result mux.

---
 rtl/addsub_pipe.sv | 134 +++++++++++++
 1 files changed

// File: rtl/addsub_pipe.sv
// Pipelined add/subtract unit: each stage resolves one SLICE-bit slice and hands its
// carry to the next. A single global advance either shifts or freezes the whole pipe.

module addsub_stage #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8,
  parameter int IDX   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv_i,
  input  logic             vld_i,
  input  logic             cin_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] bx_i,
  input  logic [WIDTH-1:0] res_i,
  output logic             vld_o,
  output logic             cout_o,
  output logic             ovf_o,
  output logic             zero_o,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] bx_o,
  output logic [WIDTH-1:0] res_o
);
  logic [SLICE:0]   sum;
  logic [WIDTH-1:0] res_d;
  logic             ovf_d, zero_d;
  logic             vld_q, cout_q, ovf_q, zero_q;
  logic [WIDTH-1:0] a_q, bx_q, res_q;

  always_comb begin
    sum   = {1'b0, a_i[IDX*SLICE +: SLICE]} + {1'b0, bx_i[IDX*SLICE +: SLICE]}
          + {{SLICE{1'b0}}, cin_i};
    res_d = res_i;
    res_d[IDX*SLICE +: SLICE] = sum[SLICE-1:0];
    // Flags are only consumed from the last stage, where res_d is fully resolved.
    ovf_d  = (a_i[WIDTH-1] == bx_i[WIDTH-1]) && (res_d[WIDTH-1] != a_i[WIDTH-1]);
    zero_d = (res_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      a_q    <= '0;
      bx_q   <= '0;
      res_q  <= '0;
    end else if (adv_i) begin
      vld_q  <= vld_i;
      cout_q <= sum[SLICE];
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
      a_q    <= a_i;
      bx_q   <= bx_i;
      res_q  <= res_d;
    end
  end

  assign vld_o  = vld_q;
  assign cout_o = cout_q;
  assign ovf_o  = ovf_q;
  assign zero_o = zero_q;
  assign a_o    = a_q;
  assign bx_o   = bx_q;
  assign res_o  = res_q;
endmodule

module addsub_pipe #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);
  localparam int STAGES = WIDTH / SLICE;

  if (WIDTH < 2 || SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_cfg
    $error("addsub_pipe: WIDTH (%0d) must be >= 2 and a multiple of SLICE (%0d)", WIDTH, SLICE);
  end

  logic                       adv;
  logic [STAGES:0]            vld_pipe, c_pipe;
  logic [STAGES:0][WIDTH-1:0] a_pipe, bx_pipe, res_pipe;
  logic [STAGES-1:0]          ovf_st, zero_st;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Entry point: B is inverted up front so every stage is a plain adder.
  assign vld_pipe[0] = in_valid;
  assign c_pipe[0]   = in_sub;
  assign a_pipe[0]   = in_a;
  assign bx_pipe[0]  = in_sub ? ~in_b : in_b;
  assign res_pipe[0] = '0;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    addsub_stage #(.WIDTH(WIDTH), .SLICE(SLICE), .IDX(k)) u_stage (
      .clk    (clk),
      .rst_n  (rst_n),
      .adv_i  (adv),
      .vld_i  (vld_pipe[k]),
      .cin_i  (c_pipe[k]),
      .a_i    (a_pipe[k]),
      .bx_i   (bx_pipe[k]),
      .res_i  (res_pipe[k]),
      .vld_o  (vld_pipe[k+1]),
      .cout_o (c_pipe[k+1]),
      .ovf_o  (ovf_st[k]),
      .zero_o (zero_st[k]),
      .a_o    (a_pipe[k+1]),
      .bx_o   (bx_pipe[k+1]),
      .res_o  (res_pipe[k+1])
    );
  end

  assign out_valid  = vld_pipe[STAGES];
  assign out_result = res_pipe[STAGES];
  assign out_cout   = c_pipe[STAGES];
  assign out_ovf    = ovf_st[STAGES-1];
  assign out_zero   = zero_st[STAGES-1];
endmodule
